// File: rtl/s4ga_seq.sv
// s4ga array sequencer: resets the LUT array, then streams each packed LUT
// config word into the array as SI_W-bit segments, one array clock per segment.
//
// state        | meaning
// RESET_HOLD   | ga_rst high, N+2 array clock pulses
// IDLE         | waiting for run / init
// FETCH        | cfg_ready high, waiting for cfg_valid; array frozen
// SHIFT        | two phases per segment: data with ga_clk low, then ga_clk high
module s4ga_seq #(
  parameter  int N         = 89,
  parameter  int K         = 5,
  parameter  int SI_W      = 4,
  parameter  int GEN_W     = 16,
  localparam int N_W       = $clog2(N),
  localparam int MASK_W    = 1 << K,
  localparam int IDX_SEGS  = (N_W + SI_W - 1) / SI_W,
  localparam int MASK_SEGS = (MASK_W + SI_W - 1) / SI_W,
  localparam int SEGS      = K * IDX_SEGS + MASK_SEGS,
  localparam int CFG_W     = SEGS * SI_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             run,
  input  logic             stop,
  input  logic [GEN_W-1:0] gens,
  output logic [N_W-1:0]   cfg_addr,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] cfg_data,
  output logic             cfg_ready,
  output logic             ga_clk,
  output logic             ga_rst,
  output logic [SI_W-1:0]  ga_si,
  output logic             busy,
  output logic [N_W-1:0]   lut_idx,
  output logic [GEN_W-1:0] gen_cnt,
  output logic             done
);

  localparam int RC_W  = N_W + 1;
  localparam int SEG_W = $clog2(SEGS + 1);
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(N + 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(SEGS - 1);
  localparam logic [N_W-1:0]   LUT_LAST = N_W'(N - 1);

  typedef enum logic [1:0] {S_RESET_HOLD, S_IDLE, S_FETCH, S_SHIFT} state_t;

  state_t           r_state;
  logic             r_phase;
  logic [RC_W-1:0]  r_rcnt;
  logic [SEG_W-1:0] r_seg;
  logic [CFG_W-1:0] r_shreg;
  logic             r_ga_clk;
  logic             r_ga_rst;
  logic [SI_W-1:0]  r_ga_si;
  logic             r_cfg_ready;
  logic             r_done;
  logic             r_busy;
  logic [N_W-1:0]   r_lut_idx;
  logic [GEN_W-1:0] r_gen_cnt;
  logic [GEN_W-1:0] r_gens;
  logic             r_stop;
  logic             r_init;

  logic             w_lut_wrap;
  logic [N_W-1:0]   w_lut_nxt;
  logic [GEN_W-1:0] w_gen_nxt;

  assign w_lut_wrap = (r_lut_idx == LUT_LAST);
  assign w_lut_nxt  = w_lut_wrap ? '0 : r_lut_idx + N_W'(1);
  assign w_gen_nxt  = r_gen_cnt + GEN_W'(w_lut_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RESET_HOLD;
      r_phase     <= 1'b0;
      r_rcnt      <= RC_LOAD;
      r_seg       <= '0;
      r_shreg     <= '0;
      r_ga_clk    <= 1'b0;
      r_ga_rst    <= 1'b1;
      r_ga_si     <= '0;
      r_cfg_ready <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b1;
      r_lut_idx   <= '0;
      r_gen_cnt   <= '0;
      r_gens      <= '0;
      r_stop      <= 1'b0;
      r_init      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (stop && r_state != S_IDLE) r_stop <= 1'b1;
      if (init && (r_state == S_FETCH || r_state == S_SHIFT)) r_init <= 1'b1;
      case (r_state)
        S_RESET_HOLD: begin
          if (!r_phase) begin
            r_ga_clk <= 1'b1;
            r_phase  <= 1'b1;
          end else begin
            r_ga_clk <= 1'b0;
            r_phase  <= 1'b0;
            if (r_rcnt == '0) begin
              r_state  <= S_IDLE;
              r_ga_rst <= 1'b0;
              r_busy   <= 1'b0;
              r_stop   <= 1'b0;
            end else begin
              r_rcnt <= r_rcnt - RC_W'(1);
            end
          end
        end
        S_IDLE: begin
          if (run) begin
            r_state     <= S_FETCH;
            r_lut_idx   <= '0;
            r_gen_cnt   <= '0;
            r_gens      <= gens;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b1;
          end else if (init) begin
            r_state  <= S_RESET_HOLD;
            r_phase  <= 1'b0;
            r_rcnt   <= RC_LOAD;
            r_ga_rst <= 1'b1;
            r_ga_si  <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_FETCH: begin
          // FETCH sits on a LUT boundary, so a pending init or stop acts here
          if (r_init || init) begin
            r_state     <= S_RESET_HOLD;
            r_phase     <= 1'b0;
            r_rcnt      <= RC_LOAD;
            r_ga_rst    <= 1'b1;
            r_ga_si     <= '0;
            r_cfg_ready <= 1'b0;
            r_init      <= 1'b0;
          end else if (r_stop || stop) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_stop      <= 1'b0;
          end else if (cfg_valid) begin
            r_state     <= S_SHIFT;
            r_cfg_ready <= 1'b0;
            r_shreg     <= cfg_data;
            r_ga_si     <= cfg_data[CFG_W-1 -: SI_W];
            r_seg       <= SEG_LAST;
            r_phase     <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!r_phase) begin
            r_ga_clk <= 1'b1;
            r_phase  <= 1'b1;
          end else begin
            r_ga_clk <= 1'b0;
            r_phase  <= 1'b0;
            r_shreg  <= {r_shreg[CFG_W-SI_W-1:0], {SI_W{1'b0}}};
            if (r_seg != '0) begin
              r_seg   <= r_seg - SEG_W'(1);
              r_ga_si <= r_shreg[CFG_W-SI_W-1 -: SI_W];
            end else begin
              r_lut_idx <= w_lut_nxt;
              r_gen_cnt <= w_gen_nxt;
              if (r_init || init) begin
                r_state  <= S_RESET_HOLD;
                r_rcnt   <= RC_LOAD;
                r_ga_rst <= 1'b1;
                r_ga_si  <= '0;
                r_init   <= 1'b0;
              end else if (w_lut_wrap && r_gens != '0 && w_gen_nxt == r_gens) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_stop  <= 1'b0;
              end else if (r_stop || stop) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_stop  <= 1'b0;
              end else begin
                r_state     <= S_FETCH;
                r_cfg_ready <= 1'b1;
              end
            end
          end
        end
        default: r_state <= S_RESET_HOLD;
      endcase
    end
  end

  assign cfg_addr  = r_lut_idx;
  assign cfg_ready = r_cfg_ready;
  assign ga_clk    = r_ga_clk;
  assign ga_rst    = r_ga_rst;
  assign ga_si     = r_ga_si;
  assign busy      = r_busy;
  assign lut_idx   = r_lut_idx;
  assign gen_cnt   = r_gen_cnt;
  assign done      = r_done;

endmodule
